// File: rtl/burst_cycle_gen_if.sv
// burst_cycle_gen_if: control and status bundle between a burst controller (master) and burst_cycle_gen (slave)
interface burst_cycle_gen_if #(parameter int CNT_W = 16);
  logic             Enable;
  logic             Trig;
  logic             Cycle_Done;
  logic [CNT_W-1:0] Burst_Count;
  logic [CNT_W-1:0] Burst_Delay;
  logic             Burst_Gate;
  logic             Busy;
  logic             Burst_Done;
  modport master (
    output Enable, Trig, Cycle_Done, Burst_Count, Burst_Delay,
    input  Burst_Gate, Busy, Burst_Done
  );
  modport slave (
    input  Enable, Trig, Cycle_Done, Burst_Count, Burst_Delay,
    output Burst_Gate, Busy, Burst_Done
  );
endinterface

// File: rtl/burst_cycle_gen.sv
// burst_cycle_gen: trigger-started burst gate with start delay and waveform-period count.
// Define BURST_INFINITE_EN to make a latched Burst_Count of 0 an endless burst.
module burst_cycle_gen #(
  parameter int CNT_W = 16
) (
  input logic              Clock,
  input logic              Reset,
  burst_cycle_gen_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DELAY, BURST} state_t;
  state_t           state, state_nx;
  logic             trig_d, armed, trig_edge, count_ok, infinite, latch, done_nx, dly_hit, per_hit;
  logic [CNT_W-1:0] cnt_l, dly_l, dly_cnt, dly_cnt_nx, per_cnt, per_cnt_nx, per_inc;
  // armed blocks a Trig already high out of reset from looking like an edge
  assign trig_edge = bus.Trig & ~trig_d & armed;
  assign per_inc   = per_cnt + CNT_W'(1);
  assign dly_hit   = dly_cnt == dly_l;
  assign per_hit   = per_inc == cnt_l;
`ifdef BURST_INFINITE_EN
  assign count_ok = 1'b1;
  assign infinite = cnt_l == '0;
`else
  assign count_ok = bus.Burst_Count != '0;
  assign infinite = 1'b0;
`endif
  always_comb begin
    state_nx   = state;
    dly_cnt_nx = dly_cnt;
    per_cnt_nx = per_cnt;
    done_nx    = 1'b0;
    latch      = 1'b0;
    if (!bus.Enable) begin
      state_nx   = IDLE;
      dly_cnt_nx = '0;
      per_cnt_nx = '0;
    end else begin
      case (state)
        IDLE: if (trig_edge && count_ok) begin
          latch      = 1'b1;
          state_nx   = bus.Burst_Delay == '0 ? BURST : DELAY;
          dly_cnt_nx = bus.Burst_Delay == '0 ? '0 : CNT_W'(1);
          per_cnt_nx = '0;
        end
        DELAY: begin
          state_nx   = dly_hit ? BURST : DELAY;
          dly_cnt_nx = dly_hit ? '0 : dly_cnt + CNT_W'(1);
        end
        BURST: if (bus.Cycle_Done && !infinite) begin
          state_nx   = per_hit ? IDLE : BURST;
          done_nx    = per_hit;
          per_cnt_nx = per_hit ? '0 : per_inc;
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      trig_d         <= 1'b0;
      armed          <= 1'b0;
      cnt_l          <= '0;
      dly_l          <= '0;
      dly_cnt        <= '0;
      per_cnt        <= '0;
      bus.Burst_Gate <= 1'b0;
      bus.Busy       <= 1'b0;
      bus.Burst_Done <= 1'b0;
    end else begin
      state          <= state_nx;
      trig_d         <= bus.Trig;
      armed          <= armed | ~bus.Trig;
      dly_cnt        <= dly_cnt_nx;
      per_cnt        <= per_cnt_nx;
      cnt_l          <= latch ? bus.Burst_Count : cnt_l;
      dly_l          <= latch ? bus.Burst_Delay : dly_l;
      bus.Burst_Gate <= state_nx == BURST;
      bus.Busy       <= state_nx != IDLE;
      bus.Burst_Done <= done_nx;
    end
  end
endmodule

// File: tb/tb_burst_cycle_gen.sv
// tb_burst_cycle_gen: scoreboard bench; a remaining-work model predicts gate/busy/done for every clock edge.
module tb_burst_cycle_gen;
  localparam int W = 16;
`ifdef BURST_INFINITE_EN
  localparam bit INF = 1'b1;
`else
  localparam bit INF = 1'b0;
`endif
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  burst_cycle_gen_if #(.CNT_W(W)) bus ();
  burst_cycle_gen #(.CNT_W(W)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  always #5 Clock = ~Clock;

  logic [2:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;
  bit m_active, m_gate, m_done, m_inf, m_prev_low;
  int m_dly, m_left;

  // Model: a burst is "active" with some delay cycles and some periods still to go.
  task automatic model_edge();
    bit rise;
    if (!Reset) begin
      m_active = 0; m_gate = 0; m_done = 0; m_prev_low = 0; m_dly = 0; m_left = 0;
    end else begin
      rise = bus.Trig && m_prev_low;
      m_done = 0;
      if (!bus.Enable) begin
        m_active = 0; m_gate = 0;
      end else if (!m_active) begin
        if (rise && (bus.Burst_Count != 0 || INF)) begin
          m_active = 1;
          m_dly = int'(bus.Burst_Delay);
          m_left = int'(bus.Burst_Count);
          m_inf = bus.Burst_Count == 0;
          m_gate = m_dly == 0;
        end
      end else if (m_dly > 0) begin
        m_dly--;
        if (m_dly == 0) m_gate = 1;
      end else if (bus.Cycle_Done && !m_inf) begin
        m_left--;
        if (m_left == 0) begin
          m_active = 0; m_gate = 0; m_done = 1;
        end
      end
      m_prev_low = !bus.Trig;
    end
    exp_q.push_back({m_gate, m_active, m_done});
  endtask

  task automatic step(input logic en, input logic tr, input logic cd, input int cnt, input int dly);
    @(negedge Clock);
    Reset = 1'b1;
    bus.Enable = en;
    bus.Trig = tr;
    bus.Cycle_Done = cd;
    bus.Burst_Count = W'(cnt);
    bus.Burst_Delay = W'(dly);
    model_edge();
  endtask

  task automatic reset_async();
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    compared++;
    if ({bus.Burst_Gate, bus.Busy, bus.Burst_Done} !== 3'b000) begin
      mismatched++;
      $display("FAIL async_reset gate/busy/done got %b want 000 at %0t", {bus.Burst_Gate, bus.Busy, bus.Burst_Done}, $time);
    end
    model_edge();
  endtask

  always @(posedge Clock) begin
    logic [2:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if ({bus.Burst_Gate, bus.Busy, bus.Burst_Done} !== e) begin
        mismatched++;
        $display("FAIL outputs gate/busy/done got %b want %b at %0t", {bus.Burst_Gate, bus.Busy, bus.Burst_Done}, e, $time);
      end
    end
  end

  initial begin
    logic tr;
    bus.Enable = 0; bus.Trig = 1; bus.Cycle_Done = 0; bus.Burst_Count = '0; bus.Burst_Delay = '0;
    #2 Reset = 1'b0;
    #1;
    compared++;
    if ({bus.Burst_Gate, bus.Busy, bus.Burst_Done} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_state got %b want 000", {bus.Burst_Gate, bus.Busy, bus.Burst_Done});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      model_edge();
    end
    // Trig high straight out of reset must not start a burst
    for (int c = 0; c < 5; c++) step(1, 1, 0, 3, 0);
    // count 3, no delay, Cycle_Done every 8 cycles; Trig held high afterwards
    for (int c = 0; c < 3; c++) step(1, 0, 0, 3, 0);
    for (int c = 0; c < 32; c++) step(1, 1, c % 8 == 7, 3, 0);
    // count 2, delay 5; Cycle_Done pulses during the delay are ignored
    step(1, 0, 0, 2, 5);
    for (int c = 0; c < 20; c++) step(1, 1, c % 2, 2, 5);
    // count 4 running; retrigger and count change mid-burst have no effect
    step(1, 0, 0, 4, 0);
    for (int c = 0; c < 30; c++) step(1, c < 3 || (c >= 8 && c < 11), c % 5 == 4, c < 6 ? 4 : 1, 0);
    // enable dropped after one of three periods
    step(1, 0, 0, 3, 0);
    for (int c = 0; c < 12; c++) step(c != 6, 1, c % 5 == 4, 3, 0);
    // reset in the middle of a long delay
    step(1, 0, 0, 2, 10);
    for (int c = 0; c < 4; c++) step(1, 1, 0, 2, 10);
    reset_async();
    for (int c = 0; c < 3; c++) step(1, 0, 0, 2, 10);
    // trigger edge coincident with the done edge is ignored
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 1, 1, 0);
    for (int c = 0; c < 4; c++) step(1, 1, c == 1, 1, 0);
    // trigger edge with enable low is ignored
    step(1, 0, 0, 2, 0);
    step(0, 1, 0, 2, 0);
    for (int c = 0; c < 3; c++) step(1, 1, 0, 2, 0);
    // count 0: ignored by default, endless burst with the infinite option
    step(1, 0, 0, 0, 0);
`ifdef BURST_INFINITE_EN
    for (int c = 0; c < 260; c++) step(1, 1, c % 2, 0, 0);
    for (int c = 0; c < 3; c++) step(0, 1, 1, 0, 0);
`else
    for (int c = 0; c < 20; c++) step(1, 1, c % 2, 0, 0);
`endif
    // randomized traffic
    tr = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) reset_async();
      if ($urandom_range(0, 3) == 0) tr = ~tr;
      step($urandom_range(0, 39) != 0, tr, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
    end
    for (int c = 0; c < 3; c++) step(1, 0, 0, 0, 0);
    @(posedge Clock);
    #3;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain leftover expectations got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
